// File: rtl/usb_rx_unstuff.sv
// usb_rx_unstuff: NRZI decoder and bit-unstuffer for the USB receive path.
// Each accepted sample is decoded against the previous line level; after
// STUFF_LEN consecutive decoded ones the next slot is treated as a stuff bit.
// That slot is dropped, and it is flagged as an error if it decodes as a 1.
module usb_rx_unstuff #(
  parameter int STUFF_LEN = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rcv_active,
  input  logic       sample_en,
  input  logic       d_line,
  output logic       data_bit,
  output logic       shift_enable,
  output logic       stuff_err,
  output logic [2:0] ones_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam logic [2:0] STUFF_LEN_W = 3'(STUFF_LEN);

  state_t     state_q, state_d;
  logic       prev_line_q, prev_line_d;
  logic       data_bit_q, data_bit_d;
  logic       shift_enable_q, shift_enable_d;
  logic       stuff_err_q, stuff_err_d;
  logic [2:0] ones_cnt_q, ones_cnt_d;
  logic       dec_bit;
  logic [2:0] ones_new;

  assign data_bit     = data_bit_q;
  assign shift_enable = shift_enable_q;
  assign stuff_err    = stuff_err_q;
  assign ones_cnt     = ones_cnt_q;

  // Next-state logic: decode the sample, count the run of ones, drop stuff slots.
  always_comb begin
    state_d        = state_q;
    prev_line_d    = prev_line_q;
    data_bit_d     = data_bit_q;
    shift_enable_d = 1'b0;
    stuff_err_d    = stuff_err_q;
    ones_cnt_d     = ones_cnt_q;
    // A level that did not change is a decoded 1.
    dec_bit        = (d_line == prev_line_q);
    ones_new       = dec_bit ? (ones_cnt_q + 3'd1) : 3'd0;

    if (!rcv_active) begin
      // Packet over or aborted: clear everything so the next packet starts clean,
      // including any pending stuff slot.
      state_d     = IDLE;
      prev_line_d = 1'b1;
      ones_cnt_d  = 3'd0;
      stuff_err_d = 1'b0;
    end else if (sample_en) begin
      // The line history advances on every accepted sample, stuff slots included.
      prev_line_d = d_line;
      if (state_q == DROP) begin
        ones_cnt_d = 3'd0;
        state_d    = COUNT;
        if (dec_bit) begin
          stuff_err_d = 1'b1;
        end
      end else begin
        // IDLE with rcv_active high behaves exactly like COUNT for this sample.
        shift_enable_d = 1'b1;
        data_bit_d     = dec_bit;
        ones_cnt_d     = ones_new;
        state_d        = (ones_new == STUFF_LEN_W) ? DROP : COUNT;
      end
    end else if (state_q == IDLE) begin
      state_d = COUNT;
    end
  end

  // State and registered outputs, with asynchronous reset to line-idle values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      prev_line_q    <= 1'b1;
      data_bit_q     <= 1'b1;
      shift_enable_q <= 1'b0;
      stuff_err_q    <= 1'b0;
      ones_cnt_q     <= 3'd0;
    end else begin
      state_q        <= state_d;
      prev_line_q    <= prev_line_d;
      data_bit_q     <= data_bit_d;
      shift_enable_q <= shift_enable_d;
      stuff_err_q    <= stuff_err_d;
      ones_cnt_q     <= ones_cnt_d;
    end
  end

endmodule

// File: tb/tb_usb_rx_unstuff.sv
// Directed bench for usb_rx_unstuff: a per-cycle vector table plus hand-written
// sequences for async reset and the STUFF_LEN = 1 corner.
module tb_usb_rx_unstuff;

  logic       clk = 1'b0;
  logic       rst;
  logic       rcv_active;
  logic       sample_en;
  logic       d_line;
  logic       data_bit, shift_enable, stuff_err;
  logic [2:0] ones_cnt;
  logic       data_bit1, shift_enable1, stuff_err1;
  logic [2:0] ones_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  usb_rx_unstuff #(.STUFF_LEN(6)) dut (
    .clk(clk), .rst(rst), .rcv_active(rcv_active), .sample_en(sample_en),
    .d_line(d_line), .data_bit(data_bit), .shift_enable(shift_enable),
    .stuff_err(stuff_err), .ones_cnt(ones_cnt)
  );

  usb_rx_unstuff #(.STUFF_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .rcv_active(rcv_active), .sample_en(sample_en),
    .d_line(d_line), .data_bit(data_bit1), .shift_enable(shift_enable1),
    .stuff_err(stuff_err1), .ones_cnt(ones_cnt1)
  );

  typedef struct packed {
    logic       ra;
    logic       se;
    logic       d;
    logic       e_data;
    logic       e_shift;
    logic       e_err;
    logic [2:0] e_ones;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ra, input logic se, input logic d,
                     input logic ed, input logic es, input logic ee, input logic [2:0] eo);
    vec_t v;
    v.ra = ra; v.se = se; v.d = d;
    v.e_data = ed; v.e_shift = es; v.e_err = ee; v.e_ones = eo;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive on the falling edge, then look at the outputs just after the rising edge.
  task automatic step(input logic ra, input logic se, input logic d);
    @(negedge clk);
    rcv_active = ra; sample_en = se; d_line = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic ed, input logic es,
                          input logic ee, input logic [2:0] eo);
    chk({tag, ".data_bit"}, {3'd0, data_bit}, {3'd0, ed});
    chk({tag, ".shift_enable"}, {3'd0, shift_enable}, {3'd0, es});
    chk({tag, ".stuff_err"}, {3'd0, stuff_err}, {3'd0, ee});
    chk({tag, ".ones_cnt"}, {1'b0, ones_cnt}, {1'b0, eo});
  endtask

  task automatic chk_len1(input string tag, input logic ed, input logic es,
                          input logic ee, input logic [2:0] eo);
    chk({tag, ".data_bit"}, {3'd0, data_bit1}, {3'd0, ed});
    chk({tag, ".shift_enable"}, {3'd0, shift_enable1}, {3'd0, es});
    chk({tag, ".stuff_err"}, {3'd0, stuff_err1}, {3'd0, ee});
    chk({tag, ".ones_cnt"}, {1'b0, ones_cnt1}, {1'b0, eo});
  endtask

  initial begin
    rst = 1'b1; rcv_active = 1'b0; sample_en = 1'b0; d_line = 1'b1;

    // Reset held with sample_en toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sample_en = ~sample_en;
      rcv_active = 1'b1;
      d_line = 1'b0;
    end
    #1;
    chk_main("reset", 1'b1, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    rst = 1'b0; rcv_active = 1'b0; sample_en = 1'b0; d_line = 1'b1;

    // ---- vector table: ra se d | data shift err ones ----
    // Idle: samples ignored while rcv_active is low.
    add(0, 1, 0,  1, 0, 0, 3'd0);
    add(0, 1, 1,  1, 0, 0, 3'd0);
    // NRZI decode: line 0,1,0,1,1,1 -> bits 0,0,0,0,1,1.
    add(1, 1, 0,  0, 1, 0, 3'd0);
    add(1, 1, 1,  0, 1, 0, 3'd0);
    add(1, 1, 0,  0, 1, 0, 3'd0);
    add(1, 1, 1,  0, 1, 0, 3'd0);
    add(1, 1, 1,  1, 1, 0, 3'd1);
    add(1, 1, 1,  1, 1, 0, 3'd2);
    add(1, 0, 1,  1, 0, 0, 3'd2);   // no strobe: pulse gone, count held
    add(0, 0, 1,  1, 0, 0, 3'd0);   // packet end clears count
    // Stuff removal: six 1s, stuff slot (transition), then 1, 0.
    add(1, 1, 1,  1, 1, 0, 3'd1);
    add(1, 1, 1,  1, 1, 0, 3'd2);
    add(1, 1, 1,  1, 1, 0, 3'd3);
    add(1, 1, 1,  1, 1, 0, 3'd4);
    add(1, 1, 1,  1, 1, 0, 3'd5);
    add(1, 1, 1,  1, 1, 0, 3'd6);
    add(1, 1, 0,  1, 0, 0, 3'd0);   // stuff slot dropped
    add(1, 1, 0,  1, 1, 0, 3'd1);
    add(1, 1, 1,  0, 1, 0, 3'd0);
    add(0, 0, 1,  0, 0, 0, 3'd0);
    // Stuff violation: seventh 1 in the stuff slot.
    add(1, 1, 1,  1, 1, 0, 3'd1);
    add(1, 1, 1,  1, 1, 0, 3'd2);
    add(1, 1, 1,  1, 1, 0, 3'd3);
    add(1, 1, 1,  1, 1, 0, 3'd4);
    add(1, 1, 1,  1, 1, 0, 3'd5);
    add(1, 1, 1,  1, 1, 0, 3'd6);
    add(1, 1, 1,  1, 0, 1, 3'd0);   // violation, no pulse
    add(1, 1, 0,  0, 1, 1, 3'd0);   // decoding continues, error sticky
    add(1, 1, 0,  1, 1, 1, 3'd1);
    add(0, 0, 0,  1, 0, 0, 3'd0);   // rcv_active low clears error
    // Abort in DROP, then restart from line-idle history.
    add(1, 1, 1,  1, 1, 0, 3'd1);
    add(1, 1, 1,  1, 1, 0, 3'd2);
    add(1, 1, 1,  1, 1, 0, 3'd3);
    add(1, 1, 1,  1, 1, 0, 3'd4);
    add(1, 1, 1,  1, 1, 0, 3'd5);
    add(1, 1, 1,  1, 1, 0, 3'd6);
    add(0, 1, 0,  1, 0, 0, 3'd0);   // abort with concurrent strobe
    add(1, 1, 1,  1, 1, 0, 3'd1);   // prev_line back to 1 -> decoded 1
    add(0, 0, 1,  1, 0, 0, 3'd0);

    foreach (vecs[i]) begin
      step(vecs[i].ra, vecs[i].se, vecs[i].d);
      $display("vec %0d ra=%0d se=%0d d=%0d -> data=%0d shift=%0d err=%0d ones=%0d",
               i, vecs[i].ra, vecs[i].se, vecs[i].d, data_bit, shift_enable, stuff_err, ones_cnt);
      chk_main($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_shift,
               vecs[i].e_err, vecs[i].e_ones);
    end

    // Async reset mid-packet with ones_cnt = 4.
    for (int i = 0; i < 4; i++) step(1, 1, 1);
    $display("pre-reset ones=%0d shift=%0d", ones_cnt, shift_enable);
    chk_main("prerst", 1'b1, 1'b1, 1'b0, 3'd4);
    #2;
    rst = 1'b1;
    #1;
    $display("async reset -> data=%0d shift=%0d err=%0d ones=%0d",
             data_bit, shift_enable, stuff_err, ones_cnt);
    chk_main("asyncrst", 1'b1, 1'b0, 1'b0, 3'd0);
    @(posedge clk);
    #1;
    chk_main("rsthold", 1'b1, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    rst = 1'b0; rcv_active = 1'b0; sample_en = 1'b0;

    // STUFF_LEN = 1: every decoded 1 is followed by a stuff slot.
    step(0, 0, 1);
    step(1, 1, 1);
    $display("len1 one -> data=%0d shift=%0d err=%0d ones=%0d", data_bit1, shift_enable1, stuff_err1, ones_cnt1);
    chk_len1("len1.one", 1'b1, 1'b1, 1'b0, 3'd1);
    step(1, 1, 1);
    $display("len1 slot -> data=%0d shift=%0d err=%0d ones=%0d", data_bit1, shift_enable1, stuff_err1, ones_cnt1);
    chk_len1("len1.slot", 1'b1, 1'b0, 1'b1, 3'd0);
    step(1, 1, 0);
    $display("len1 zero -> data=%0d shift=%0d err=%0d ones=%0d", data_bit1, shift_enable1, stuff_err1, ones_cnt1);
    chk_len1("len1.zero", 1'b0, 1'b1, 1'b1, 3'd0);
    step(0, 0, 1);
    chk_len1("len1.end", 1'b0, 1'b0, 1'b0, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
